alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one ALU instance (16-bit, 3-bit func) between NREQ requesters, e.g. the execute stage and a debug/address-gen port.
- Round-robin arbitration, valid/ready request handshake, operands captured into registers, ALU evaluated for one cycle, result held on a valid/ready response port tagged with the requester id.
- Turns the shared ALU into a multi-cycle resource with one operation in flight.

Parameters:
- WIDTH, 16, datapath width; passed to the ALU's n parameter.
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_func  input  3*NREQ  func per requester; slice i = bits [3i+2:3i]. Encoding: MOV=000, ADD=001, SUB=010, AND=011, OR=100, NOT=101, NOP=110, 111 reserved.
- req_a  input  WIDTH*NREQ  operand 1 per requester, slice i.
- req_b  input  WIDTH*NREQ  operand 2 per requester, slice i.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE; req_ready = 0; rsp_valid = 0.
  - rsp_data = 0; rsp_id = 0; busy = 0.
  - rr_ptr = 0; last_result = 0; internal operand/func registers = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: only the winner's bit is high.
  - Winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - On a clock edge with any req_valid: capture the winner's func/a/b/id, set rr_ptr = (winner+1) mod NREQ, go to EXEC.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- EXEC (one cycle):
  - ALU inputs driven from the captured registers.
  - At the edge: rsp_data <= ALU out, rsp_id <= captured id, rsp_valid <= 1, last_result <= result; go to RESP.
- NOP/reserved funcs:
  - For func 110 or 111, the ALU is driven with MOV (000) and inp2 = last_result, so rsp_data = last_result.
  - The ALU never sees 110/111, which avoids its combinational hold path.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are stable.
  - If rsp_ready: rsp_valid <= 0, go to IDLE.
  - Otherwise hold indefinitely.
  - req_ready = 0 in EXEC and RESP.
- Latency and throughput:
  - Accept at edge T; rsp_valid visible after edge T+1.
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP); no back-to-back accepts.
- Arithmetic: width WIDTH; ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- Requester rules:
  - A requester must hold req_valid and its operands stable until its req_ready is seen.
  - Dropping req_valid early is legal; the request is simply not accepted.
- Simultaneous events: all requesters valid yields strict rotation. With NREQ=2 and both always valid, grants go 0,1,0,1…
- Asynchronous reset mid-operation: immediately returns to IDLE with the reset values above; any in-flight result is discarded.

Optional Feature:
- Macro: ALU_SHARE_FLAGS_EN.
- Defined:
  - Adds output rsp_zero (1 bit) and output rsp_neg (1 bit), registered alongside rsp_data in EXEC.
  - rsp_zero = (result == 0); rsp_neg = result[WIDTH-1].
  - Both reset to 0 and are held through RESP.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-RESP with rsp_data=0x1234 -> rsp_valid=0, rsp_data=0, busy=0 immediately, without waiting for a clock edge.
- Single ADD: req0 func=001, a=0xFFFF, b=0x0002, rsp_ready=1 -> req_ready[0] for one cycle; after 2 edges rsp_valid=1, rsp_data=0x0001, rsp_id=0.
- Round-robin: both requesters valid continuously with SUB 5-3 (req0) and AND 0xF0F0&0x0FF0 (req1), rsp_ready=1 -> responses alternate id 0 (0x0002) and id 1 (0x00F0), starting with id 0 after reset.
- Backpressure: rsp_ready=0 for 5 cycles after a NOT of b=0x00FF -> rsp_valid stays high with rsp_data=0xFF00 stable; req_ready stays all-zero; one cycle after rsp_ready=1, back in IDLE.
- NOP hold: MOV b=0x0ABC, then NOP (110) with a=b=0x1111 -> second rsp_data=0x0ABC; func 111 behaves the same.
- Flags (ALU_SHARE_FLAGS_EN defined): SUB 7-7 -> rsp_zero=1, rsp_neg=0; SUB 0-1 -> rsp_data=0xFFFF, rsp_zero=0, rsp_neg=1.

Source files
------------

// File: rtl/alu_share_if.sv
// Request/response bundle for alu_share_arbiter.
// With ALU_SHARE_FLAGS_EN defined, the interface also carries rsp_zero and rsp_neg.
interface alu_share_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_func;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef ALU_SHARE_FLAGS_EN
  logic                  rsp_zero;
  logic                  rsp_neg;

  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_neg
  );
  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_neg
  );
`else
  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 16-bit ALU between NREQ requesters, one operation in flight.
// Optional macro ALU_SHARE_FLAGS_EN adds registered rsp_zero/rsp_neg result flags.
module alu_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  parameter int IDW   = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_share_if.slave  bus,
  output logic        busy
);

  localparam logic [2:0] FN_MOV = 3'b000;
  localparam logic [2:0] FN_ADD = 3'b001;
  localparam logic [2:0] FN_SUB = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_NOT = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state;
  logic [IDW-1:0]           rr_ptr;

  logic                     win_any;
  logic [NREQ-1:0]          win_oh;
  logic [IDW-1:0]           win_id;
  logic [IDW-1:0]           nxt_ptr;
  logic [2:0]               win_func;
  logic signed [WIDTH-1:0]  win_a;
  logic signed [WIDTH-1:0]  win_b;
  logic [NREQ-1:0]          vld_sh;
  int                       idx;

  logic [2:0]               func_p0;
  logic signed [WIDTH-1:0]  a_p0;
  logic signed [WIDTH-1:0]  b_p0;
  logic [IDW-1:0]           id_p0;
  logic signed [WIDTH-1:0]  last_result;

  logic [2:0]               alu_func;
  logic signed [WIDTH-1:0]  alu_b;
  logic signed [WIDTH-1:0]  alu_y;

  logic                     vld_p1;
  logic signed [WIDTH-1:0]  rsp_data_p1;
  logic [IDW-1:0]           rsp_id_p1;
`ifdef ALU_SHARE_FLAGS_EN
  logic                     rsp_zero_p1;
  logic                     rsp_neg_p1;
`endif

  function automatic logic signed [WIDTH-1:0] alu_eval(
    input logic [2:0]              fn,
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    case (fn)
      FN_MOV:  return y;
      FN_ADD:  return x + y;
      FN_SUB:  return x - y;
      FN_AND:  return x & y;
      FN_OR:   return x | y;
      FN_NOT:  return ~y;
      default: return y;
    endcase
  endfunction

  // Winner: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_any  = 1'b0;
    win_oh   = '0;
    win_id   = '0;
    nxt_ptr  = rr_ptr;
    win_func = '0;
    win_a    = '0;
    win_b    = '0;
    vld_sh   = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx    = (int'(rr_ptr) + k) % NREQ;
      vld_sh = bus.req_valid >> idx;
      if (!win_any && vld_sh[0]) begin
        win_any  = 1'b1;
        win_oh   = NREQ'(1) << idx;
        win_id   = IDW'(idx);
        nxt_ptr  = IDW'((idx + 1) % NREQ);
        win_func = 3'(bus.req_func >> (3 * idx));
        win_a    = WIDTH'(bus.req_a >> (WIDTH * idx));
        win_b    = WIDTH'(bus.req_b >> (WIDTH * idx));
      end
    end
  end

  assign bus.req_ready = (state == IDLE) ? win_oh : '0;

  // NOP/reserved become MOV of the previous result so the ALU never sees 110/111.
  always_comb begin
    if (func_p0[2:1] == 2'b11) begin
      alu_func = FN_MOV;
      alu_b    = last_result;
    end else begin
      alu_func = func_p0;
      alu_b    = b_p0;
    end
    alu_y = alu_eval(alu_func, a_p0, alu_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rr_ptr      <= '0;
      func_p0     <= '0;
      a_p0        <= '0;
      b_p0        <= '0;
      id_p0       <= '0;
      last_result <= '0;
      vld_p1      <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_id_p1   <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      rsp_zero_p1 <= 1'b0;
      rsp_neg_p1  <= 1'b0;
`endif
    end else begin
      case (state)
        // stage p0: capture the winning request
        IDLE: begin
          if (win_any) begin
            func_p0 <= win_func;
            a_p0    <= win_a;
            b_p0    <= win_b;
            id_p0   <= win_id;
            rr_ptr  <= nxt_ptr;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        // stage p1: register the ALU result onto the response port
        EXEC: begin
          rsp_data_p1 <= alu_y;
          rsp_id_p1   <= id_p0;
          vld_p1      <= 1'b1;
          last_result <= alu_y;
`ifdef ALU_SHARE_FLAGS_EN
          rsp_zero_p1 <= (alu_y == '0);
          rsp_neg_p1  <= alu_y[WIDTH-1];
`endif
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_id    = rsp_id_p1;
`ifdef ALU_SHARE_FLAGS_EN
  assign bus.rsp_zero  = rsp_zero_p1;
  assign bus.rsp_neg   = rsp_neg_p1;
`endif

endmodule
